// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
// Shares one 32-bit BRAM controller port between two clients: client 0 (the
// sample reader) and client 1 (the result writer). At most one access is
// issued per clock. Arbitration is round-robin with a bounded burst length,
// and read data is routed back to the client that issued the read.
//
// Parameters
//   MAX_BURST : consecutive grants to one client while the other waits (1..255)
//   RD_LAT    : BRAM read latency, ram_en high to valid ram_rd_data (1 or 2)
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cN_req/wr/addr/be/wdata    : client request, held until acked
//   cN_ack                     : combinational, request accepted this cycle
//   cN_rvalid, rdata           : registered read return (rdata shared)
//   ram_clk/en/addr/we/wr_data : registered BRAM port drive
//   ram_rd_data                : BRAM read data
//   ram_rst                    : tied low
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c0_req,
    input  logic        c0_wr,
    input  logic [31:0] c0_addr,
    input  logic [3:0]  c0_be,
    input  logic [31:0] c0_wdata,
    input  logic        c1_req,
    input  logic        c1_wr,
    input  logic [31:0] c1_addr,
    input  logic [3:0]  c1_be,
    input  logic [31:0] c1_wdata,
    output logic        c0_ack,
    output logic        c1_ack,
    output logic        c0_rvalid,
    output logic        c1_rvalid,
    output logic [31:0] rdata,
    output logic        ram_clk,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wr_data,
    input  logic [31:0] ram_rd_data,
    output logic        ram_rst
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [7:0]  BURST_MAX  = 8'(MAX_BURST);
    localparam int unsigned PIPE_DEPTH = RD_LAT + 1;
    localparam int unsigned TAIL       = PIPE_DEPTH - 1;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;

    logic        owner_s;
    logic        own_req_s;
    logic        oth_req_s;
    logic        burst_done_s;
    logic        gnt_valid_s;
    logic        gnt_client_s;

    logic        sel_wr_s;
    logic [31:0] sel_addr_s;
    logic [3:0]  sel_be_s;
    logic [31:0] sel_wdata_s;

    logic [PIPE_DEPTH-1:0] tag_vld_q;
    logic [PIPE_DEPTH-1:0] tag_cli_q;

    logic        ram_en_q;
    logic [31:0] ram_addr_q;
    logic [3:0]  ram_we_q;
    logic [31:0] ram_wr_data_q;
    logic        c0_rvalid_q;
    logic        c1_rvalid_q;
    logic [31:0] rdata_q;

    // Byte offset bits are dropped: the BRAM port is word addressed.
    logic        unused_addr_bits_s;
    assign unused_addr_bits_s = ^{c0_addr[1:0], c1_addr[1:0]};

    // Arbitration state, burst counter and tie-break history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and grant selection; the owner is kept while its burst lasts
    // or while the other client is idle, so handover costs no bubble cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        gnt_valid_s  = 1'b0;
        gnt_client_s = 1'b0;
        owner_s      = (state_q == ST_OWN1);
        own_req_s    = owner_s ? c1_req : c0_req;
        oth_req_s    = owner_s ? c0_req : c1_req;
        burst_done_s = (cnt_q >= BURST_MAX);
        case (state_q)
            ST_IDLE: begin
                if (c0_req || c1_req) begin
                    gnt_valid_s = 1'b1;
                    // On a tie the client not switched to last time wins.
                    if (c0_req && c1_req) begin
                        gnt_client_s = ~last_q;
                    end else begin
                        gnt_client_s = c1_req;
                    end
                    state_d = gnt_client_s ? ST_OWN1 : ST_OWN0;
                    cnt_d   = 8'd1;
                    last_d  = gnt_client_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (own_req_s && (!burst_done_s || !oth_req_s)) begin
                    gnt_valid_s  = 1'b1;
                    gnt_client_s = owner_s;
                    cnt_d        = burst_done_s ? 8'd1 : (cnt_q + 8'd1);
                end else if (oth_req_s) begin
                    gnt_valid_s  = 1'b1;
                    gnt_client_s = ~owner_s;
                    state_d      = owner_s ? ST_OWN0 : ST_OWN1;
                    cnt_d        = 8'd1;
                    last_d       = ~owner_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request of the granted client, forwarded to the port register.
    always_comb begin
        if (gnt_client_s) begin
            sel_wr_s    = c1_wr;
            sel_addr_s  = c1_addr;
            sel_be_s    = c1_be;
            sel_wdata_s = c1_wdata;
        end else begin
            sel_wr_s    = c0_wr;
            sel_addr_s  = c0_addr;
            sel_be_s    = c0_be;
            sel_wdata_s = c0_wdata;
        end
    end

    // Acks are forced low while reset is asserted.
    assign c0_ack = rst_n & gnt_valid_s & ~gnt_client_s;
    assign c1_ack = rst_n & gnt_valid_s &  gnt_client_s;

    // BRAM port register; address and write data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q      <= 1'b0;
            ram_addr_q    <= 32'd0;
            ram_we_q      <= 4'd0;
            ram_wr_data_q <= 32'd0;
        end else if (gnt_valid_s) begin
            ram_en_q      <= 1'b1;
            ram_addr_q    <= {sel_addr_s[31:2], 2'b00};
            ram_we_q      <= sel_wr_s ? sel_be_s : 4'd0;
            ram_wr_data_q <= sel_wdata_s;
        end else begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 4'd0;
        end
    end

    // Read tag pipeline: the tail lines up with valid ram_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            tag_cli_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[PIPE_DEPTH-2:0], gnt_valid_s & ~sel_wr_s};
            tag_cli_q <= {tag_cli_q[PIPE_DEPTH-2:0], gnt_client_s};
        end
    end

    // Read return: capture BRAM data and flag the issuing client.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= 32'd0;
            c0_rvalid_q <= 1'b0;
            c1_rvalid_q <= 1'b0;
        end else begin
            c0_rvalid_q <= tag_vld_q[TAIL] & ~tag_cli_q[TAIL];
            c1_rvalid_q <= tag_vld_q[TAIL] &  tag_cli_q[TAIL];
            if (tag_vld_q[TAIL]) begin
                rdata_q <= ram_rd_data;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign ram_clk     = clk;
    assign ram_rst     = 1'b0;
    assign ram_en      = ram_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wr_data = ram_wr_data_q;
    assign rdata       = rdata_q;
    assign c0_rvalid   = c0_rvalid_q;
    assign c1_rvalid   = c1_rvalid_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench. Instance A: MAX_BURST=4, RD_LAT=1. Instance B: MAX_BURST=1,
// RD_LAT=2. Both see the same client stimulus; each has its own BRAM model.
// Inputs change 1 time unit after the rising edge and are checked 1 unit later.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c0_wr, c1_req, c1_wr;
    logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
    logic [3:0]  c0_be, c1_be;

    logic        a_c0_ack, a_c1_ack, a_c0_rvalid, a_c1_rvalid;
    logic [31:0] a_rdata, a_ram_addr, a_ram_wr_data, a_ram_rd_data;
    logic        a_ram_clk, a_ram_en, a_ram_rst;
    logic [3:0]  a_ram_we;

    logic        b_c0_ack, b_c1_ack, b_c0_rvalid, b_c1_rvalid;
    logic [31:0] b_rdata, b_ram_addr, b_ram_wr_data, b_ram_rd_data;
    logic        b_ram_clk, b_ram_en, b_ram_rst;
    logic [3:0]  b_ram_we;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.MAX_BURST(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_be(c0_be), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_be(c1_be), .c1_wdata(c1_wdata),
        .c0_ack(a_c0_ack), .c1_ack(a_c1_ack), .c0_rvalid(a_c0_rvalid), .c1_rvalid(a_c1_rvalid),
        .rdata(a_rdata), .ram_clk(a_ram_clk), .ram_en(a_ram_en), .ram_addr(a_ram_addr),
        .ram_we(a_ram_we), .ram_wr_data(a_ram_wr_data), .ram_rd_data(a_ram_rd_data),
        .ram_rst(a_ram_rst)
    );

    bram_port_arbiter #(.MAX_BURST(1), .RD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_wr(c0_wr), .c0_addr(c0_addr), .c0_be(c0_be), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_wr(c1_wr), .c1_addr(c1_addr), .c1_be(c1_be), .c1_wdata(c1_wdata),
        .c0_ack(b_c0_ack), .c1_ack(b_c1_ack), .c0_rvalid(b_c0_rvalid), .c1_rvalid(b_c1_rvalid),
        .rdata(b_rdata), .ram_clk(b_ram_clk), .ram_en(b_ram_en), .ram_addr(b_ram_addr),
        .ram_we(b_ram_we), .ram_wr_data(b_ram_wr_data), .ram_rd_data(b_ram_rd_data),
        .ram_rst(b_ram_rst)
    );

    // BRAM models: read-first, word 16 (0x40) = DEADBEEF, word 4 (0x10) = FFFFFFFF.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] a_rd1, b_rd1, b_rd2;
    bit          loaded = 1'b0;

    // Memory preload on the first edge, then one access per enabled cycle.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int w = 0; w < 64; w++) begin
                mem_a[w] <= 32'd0;
                mem_b[w] <= 32'd0;
            end
            mem_a[16] <= 32'hDEAD_BEEF;
            mem_b[16] <= 32'hDEAD_BEEF;
            mem_a[4]  <= 32'hFFFF_FFFF;
            mem_b[4]  <= 32'hFFFF_FFFF;
            loaded    <= 1'b1;
        end else begin
            if (a_ram_en) begin
                a_rd1 <= mem_a[a_ram_addr[7:2]];
                for (int k = 0; k < 4; k++)
                    if (a_ram_we[k]) mem_a[a_ram_addr[7:2]][8*k +: 8] <= a_ram_wr_data[8*k +: 8];
            end
            if (b_ram_en) begin
                b_rd1 <= mem_b[b_ram_addr[7:2]];
                for (int k = 0; k < 4; k++)
                    if (b_ram_we[k]) mem_b[b_ram_addr[7:2]][8*k +: 8] <= b_ram_wr_data[8*k +: 8];
            end
        end
        b_rd2 <= b_rd1;
    end

    assign a_ram_rd_data = a_rd1;
    assign b_ram_rd_data = b_rd2;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c0(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        c0_req = req; c0_wr = wr; c0_addr = addr; c0_be = be; c0_wdata = wdata;
    endtask

    task automatic set_c1(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        c1_req = req; c1_wr = wr; c1_addr = addr; c1_be = be; c1_wdata = wdata;
    endtask

    initial begin
        rst_n = 1'b0;
        set_c0(1'b1, 1'b0, 32'h0000_0042, 4'hF, 32'd0);
        set_c1(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        repeat (3) next_cycle();
        #1;
        // Reset state with both clients requesting.
        check_eq("rst_a_c0_ack", {31'd0, a_c0_ack}, 32'd0);
        check_eq("rst_a_c1_ack", {31'd0, a_c1_ack}, 32'd0);
        check_eq("rst_b_c0_ack", {31'd0, b_c0_ack}, 32'd0);
        check_eq("rst_a_ram_en", {31'd0, a_ram_en}, 32'd0);
        check_eq("rst_a_ram_addr", a_ram_addr, 32'd0);
        check_eq("rst_a_ram_we", {28'd0, a_ram_we}, 32'd0);
        check_eq("rst_a_wr_data", a_ram_wr_data, 32'd0);
        check_eq("rst_a_rdata", a_rdata, 32'd0);
        check_eq("rst_a_rvalid", {30'd0, a_c0_rvalid, a_c1_rvalid}, 32'd0);
        check_eq("ram_rst_a", {31'd0, a_ram_rst}, 32'd0);
        check_eq("ram_rst_b", {31'd0, b_ram_rst}, 32'd0);

        // Tie in the first cycle after release: c0 first.
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_eq("tie_a_c0_ack", {31'd0, a_c0_ack}, 32'd1);
        check_eq("tie_a_c1_ack", {31'd0, a_c1_ack}, 32'd0);
        check_eq("tie_b_c0_ack", {31'd0, b_c0_ack}, 32'd1);
        check_eq("ram_clk_a", {31'd0, a_ram_clk}, {31'd0, clk});
        check_eq("ram_clk_b", {31'd0, b_ram_clk}, {31'd0, clk});
        next_cycle();
        c0_req = 1'b0;
        #1;
        check_eq("tie_a_c1_next", {31'd0, a_c1_ack}, 32'd1);
        check_eq("tie_a_c0_next", {31'd0, a_c0_ack}, 32'd0);
        check_eq("rd_a_ram_en", {31'd0, a_ram_en}, 32'd1);
        check_eq("rd_a_ram_addr", a_ram_addr, 32'h0000_0040);
        check_eq("rd_a_ram_we", {28'd0, a_ram_we}, 32'd0);
        next_cycle();
        c1_req = 1'b0;
        #1;
        check_eq("idle_a_acks", {30'd0, a_c0_ack, a_c1_ack}, 32'd0);
        check_eq("rd_a_ram_addr1", a_ram_addr, 32'h0000_0010);
        check_eq("rd_a_c0_early", {31'd0, a_c0_rvalid}, 32'd0);
        next_cycle();
        check_eq("idle_a_ram_en", {31'd0, a_ram_en}, 32'd0);
        check_eq("hold_a_ram_addr", a_ram_addr, 32'h0000_0010);
        check_eq("rd_a_c0_rvalid", {31'd0, a_c0_rvalid}, 32'd1);
        check_eq("rd_a_c1_quiet", {31'd0, a_c1_rvalid}, 32'd0);
        check_eq("rd_a_rdata0", a_rdata, 32'hDEAD_BEEF);
        next_cycle();
        check_eq("rd_a_c1_rvalid", {31'd0, a_c1_rvalid}, 32'd1);
        check_eq("rd_a_c0_once", {31'd0, a_c0_rvalid}, 32'd0);
        check_eq("rd_a_rdata1", a_rdata, 32'hFFFF_FFFF);
        check_eq("rd_b_c0_rvalid", {31'd0, b_c0_rvalid}, 32'd1);
        check_eq("rd_b_rdata0", b_rdata, 32'hDEAD_BEEF);
        next_cycle();
        check_eq("rd_b_c1_rvalid", {31'd0, b_c1_rvalid}, 32'd1);
        check_eq("rd_b_rdata1", b_rdata, 32'hFFFF_FFFF);

        // Write then read of the same word by c1.
        next_cycle();
        set_c1(1'b1, 1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678);
        #1;
        check_eq("wr_a_c1_ack", {31'd0, a_c1_ack}, 32'd1);
        next_cycle();
        c1_wr = 1'b0;
        #1;
        check_eq("wr_a_c1_ack2", {31'd0, a_c1_ack}, 32'd1);
        check_eq("wr_a_ram_en", {31'd0, a_ram_en}, 32'd1);
        check_eq("wr_a_ram_we", {28'd0, a_ram_we}, 32'h3);
        check_eq("wr_a_wr_data", a_ram_wr_data, 32'h1234_5678);
        next_cycle();
        c1_req = 1'b0;
        #1;
        check_eq("wr_a_rd_we", {28'd0, a_ram_we}, 32'd0);
        next_cycle();
        check_eq("wr_a_no_rvalid", {31'd0, a_c1_rvalid}, 32'd0);
        next_cycle();
        check_eq("wr_a_rvalid", {31'd0, a_c1_rvalid}, 32'd1);
        check_eq("wr_a_rdata", a_rdata, 32'hFFFF_5678);
        next_cycle();
        check_eq("wr_b_rvalid", {31'd0, b_c1_rvalid}, 32'd1);
        check_eq("wr_b_rdata", b_rdata, 32'hFFFF_5678);
        repeat (3) next_cycle();

        // Fairness: A bursts 4/4, B alternates each cycle.
        set_c0(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'd0);
        set_c1(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq($sformatf("fair_a_c0_%0d", i), {31'd0, a_c0_ack}, {31'd0, ((i / 4) % 2) == 0});
            check_eq($sformatf("fair_a_c1_%0d", i), {31'd0, a_c1_ack}, {31'd0, ((i / 4) % 2) != 0});
            check_eq($sformatf("fair_b_c0_%0d", i), {31'd0, b_c0_ack}, {31'd0, (i % 2) == 0});
            if (i > 0) check_eq($sformatf("fair_a_en_%0d", i), {31'd0, a_ram_en}, 32'd1);
            next_cycle();
        end
        c0_req = 1'b0;
        c1_req = 1'b0;
        #1;
        check_eq("fair_a_en_last", {31'd0, a_ram_en}, 32'd1);
        next_cycle();
        check_eq("fair_a_en_off", {31'd0, a_ram_en}, 32'd0);
        repeat (5) next_cycle();

        // Single requester: every cycle acked, no burst cut.
        c1_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            check_eq($sformatf("solo_a_c1_%0d", i), {31'd0, a_c1_ack}, 32'd1);
            check_eq($sformatf("solo_a_c0_%0d", i), {31'd0, a_c0_ack}, 32'd0);
            next_cycle();
        end
        c1_req = 1'b0;
        repeat (6) next_cycle();

        // Reset one cycle after a c0 read ack drops the read.
        set_c0(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'd0);
        #1;
        check_eq("mid_b_c0_ack", {31'd0, b_c0_ack}, 32'd1);
        next_cycle();
        c0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_b_ram_en", {31'd0, b_ram_en}, 32'd0);
        check_eq("mid_b_ram_addr", b_ram_addr, 32'd0);
        check_eq("mid_b_rdata", b_rdata, 32'd0);
        check_eq("mid_a_ram_en", {31'd0, a_ram_en}, 32'd0);
        check_eq("mid_a_rdata", a_rdata, 32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("mid_b_drop_%0d", i), {31'd0, b_c0_rvalid}, 32'd0);
            check_eq($sformatf("mid_a_drop_%0d", i), {31'd0, a_c0_rvalid}, 32'd0);
            next_cycle();
        end
        set_c0(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'd0);
        #1;
        check_eq("new_b_c0_ack", {31'd0, b_c0_ack}, 32'd1);
        next_cycle();
        c0_req = 1'b0;
        #1;
        check_eq("new_b_ram_en", {31'd0, b_ram_en}, 32'd1);
        check_eq("new_b_ram_addr", b_ram_addr, 32'h0000_0010);
        next_cycle();
        check_eq("new_b_lat2", {31'd0, b_c0_rvalid}, 32'd0);
        next_cycle();
        check_eq("new_b_lat3", {31'd0, b_c0_rvalid}, 32'd0);
        check_eq("new_a_rvalid", {31'd0, a_c0_rvalid}, 32'd1);
        check_eq("new_a_rdata", a_rdata, 32'hFFFF_5678);
        next_cycle();
        check_eq("new_b_rvalid", {31'd0, b_c0_rvalid}, 32'd1);
        check_eq("new_b_rdata", b_rdata, 32'hFFFF_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-client arbiter sharing a single 32-bit BRAM controller port (the Zynq PS-visible block RAM) between the sample reader feeding the CORDIC pipeline (client 0) and the result writer (client 1). It issues at most one BRAM access per clock, uses round-robin with a bounded burst length, and routes returning read data back to the issuing client. The arbiter sits between the clients and the BRAM_PORT bus pins (`ram_*`) of the block design.

## Interface
Parameters:
- `MAX_BURST`, 16: maximum consecutive accesses granted to one client while the other is requesting. Range 1..255.
- `RD_LAT`, 1: BRAM read latency in cycles from `ram_en` high to valid `ram_rd_data`. Legal values are 1 and 2.

Ports:
- `clk`  in  1: single clock for all logic; also forwarded to the BRAM.
- `rst_n`  in  1: asynchronous, active-low reset.
- `c0_req`, `c1_req`  in  1 each: access request; held until acked.
- `c0_wr`, `c1_wr`  in  1 each: 1 = write, 0 = read.
- `c0_addr`, `c1_addr`  in  32 each: byte address.
- `c0_be`, `c1_be`  in  4 each: write byte enables.
- `c0_wdata`, `c1_wdata`  in  32 each: write data.
- `c0_ack`, `c1_ack`  out  1 each: combinational; request accepted this cycle.
- `c0_rvalid`, `c1_rvalid`  out  1 each: registered read-data valid, one cycle per read.
- `rdata`  out  32: registered read data, shared by both clients; qualified by `cN_rvalid`.
- `ram_clk`  out  1: equal to `clk`.
- `ram_en`  out  1: BRAM enable.
- `ram_addr`  out  32: BRAM byte address; bits [1:0] are always 0.
- `ram_we`  out  4: byte write enables.
- `ram_wr_data`  out  32: BRAM write data.
- `ram_rd_data`  in  32: BRAM read data.
- `ram_rst`  out  1: tied to 0; the BRAM output register reset is unused.

## Operation
- States are IDLE, OWN0 and OWN1. Registers: `cnt` (8 bits), `last` (client most recently switched to; resets to 1 so client 0 wins the first tie).
- IDLE:
  - A single requester is acked immediately.
  - When both request, the client != `last` is acked.
  - Next state is OWNw with `cnt`=1; `last` is set to w.
- OWNx (owner x, other y):
  - `cx_req` & (`cnt`<`MAX_BURST` | !`cy_req`): ack x. `cnt`+1, or `cnt`=1 if `cnt`==`MAX_BURST`.
  - `cx_req` & `cnt`==`MAX_BURST` & `cy_req`: ack y. Go to OWNy with `cnt`=1 and `last`=y.
  - !`cx_req` & `cy_req`: ack y. Go to OWNy with `cnt`=1 and `last`=y.
  - !`cx_req` & !`cy_req`: no ack. Go to IDLE.
- Exactly one ack per cycle whenever any request is pending. Handover inserts no bubble cycle.
- Acked access is registered onto the BRAM port in the next cycle:
  - `ram_en`=1.
  - `ram_addr`={addr[31:2],2'b00}.
  - `ram_we`= wr ? be : 4'h0.
  - `ram_wr_data`=wdata.
- When no access is acked, the next cycle drives `ram_en`=0 and `ram_we`=0. Address and data hold their previous values.
- Reads are tagged {valid, client} in a shift pipeline of depth `RD_LAT`+1. At the tail, `rdata`<=`ram_rd_data` and `cN_rvalid`<=1 for the tagged client.
- Writes generate no `rvalid`.
- Returned reads stay in issue order per client and globally.

## Timing
- Reset (async assert, sync release):
  - State IDLE, `cnt`=0, `last`=1, pipeline cleared.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wr_data`=0.
  - `rdata`=0, `c0_rvalid`=`c1_rvalid`=0.
  - Acks are 0 while `rst_n`=0.
- Reset mid-operation drops all in-flight reads: no `rvalid` is produced for them after release.
- Read acked in cycle t:
  - `ram_en` is high in cycle t+1.
  - `ram_rd_data` is valid in cycle t+1+`RD_LAT`.
  - `cN_rvalid`/`rdata` are high/valid in cycle t+2+`RD_LAT`. Total latency is `RD_LAT`+2 cycles from the ack.
- Write acked in cycle t: the BRAM write occurs at the end of cycle t+1.
- A read issued after a write to the same address returns the new data. The BRAM is read-first or write-first at a single port; ordering is preserved by issue order.
- `cnt` never exceeds `MAX_BURST`. With `MAX_BURST`=1, two continuously requesting clients alternate every cycle.

## Test plan
- Single read: `RD_LAT`=1, BRAM preloaded with word 0x0000_0040=0xDEAD_BEEF. c0 reads addr 0x42, acked in cycle 5.
  - `ram_en`=1 and `ram_addr`=0x40 in cycle 6.
  - `c0_rvalid`=1 and `rdata`=0xDEAD_BEEF in cycle 8. `c1_rvalid` stays 0.
- Write then read: c1 writes 0x1234_5678 with `be`=4'b0011 to 0x10 (old value 0xFFFF_FFFF); c1 then reads 0x10 → `rdata`=0xFFFF_5678 returned to c1.
- Tie from reset: c0 and c1 both request in the first cycle after release → c0 acked first, and c1 gets the ack the cycle c0 drops its request.
- Fairness, `MAX_BURST`=4: both clients request continuously for 20 cycles → ack pattern is 4×c0, 4×c1, repeating. `ram_en` is high for all 20 issue cycles, with no bubbles.
- Single requester: only c1 requests for 40 cycles with `MAX_BURST`=4 → all 40 are acked consecutively; `cnt` wraps 4→1.
- Reset mid-read, `RD_LAT`=2: assert `rst_n`=0 one cycle after a c0 read ack →
  - All outputs are 0 immediately.
  - After release, no `c0_rvalid` is produced for the dropped read.
  - A new read completes with latency 4.
